// File: rtl/vga_rx_timing.sv
// VGA receive timing recovery: measures raster geometry, locks onto it, and regenerates
// pixel coordinates, data-enable and aligned RGB from the incoming syncs.
module vga_rx_timing #(
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_DISP   = 640,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_DISP   = 480,
    parameter int unsigned SYNC_POL = 0,
    parameter int unsigned CW       = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          r_in,
    input  logic          g_in,
    input  logic          b_in,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de,
    output logic          r_out,
    output logic          g_out,
    output logic          b_out,
    output logic          frame_start,
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] h_sw,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] v_sw
);

    localparam logic [CW-1:0] HC_MAX   = '1;
    localparam logic [CW-1:0] H_BACK_W = CW'(H_BACK);
    localparam logic [CW-1:0] H_DISP_W = CW'(H_DISP);
    localparam logic [CW-1:0] V_BACK_W = CW'(V_BACK);
    localparam logic [CW-1:0] V_DISP_W = CW'(V_DISP);

    typedef enum logic [1:0] {StSearch, StMeasure, StVerify, StLocked} state_e;

    state_e        state_q, state_d;
    logic          hs1_q, hs2_q, vs1_q, vs2_q;
    logic [2:0]    rgb1_q;
    logic [CW-1:0] hc_q, vc_q, hc_cur, vc_cur;
    logic          vpend_q;
    logic [CW-1:0] hsw_tmp_q, vsw_cnt_q, vsw_tmp_q;
    logic          first_q, first_d;
    logic [CW-1:0] ref_ht_q, ref_hsw_q, ref_vt_q, ref_vsw_q;
    logic [CW-1:0] ref_ht_d, ref_hsw_d, ref_vt_d, ref_vsw_d;
    logic          err_d, load_out;
    logic          hs_in, vs_in, hedge, hfall, vedge, vfall, frame_evt, timeout;
    logic [CW-1:0] line_len, frame_len;
    logic          line_ok, frame_ok;
    logic [CW-1:0] h_start, v_start, x_d, y_d;
    logic          h_in, v_in, de_d;

    assign hs_in = (SYNC_POL != 0) ? hsync : ~hsync;
    assign vs_in = (SYNC_POL != 0) ? vsync : ~vsync;

    assign hedge = hs1_q & ~hs2_q;
    assign hfall = ~hs1_q & hs2_q;
    assign vedge = vs1_q & ~vs2_q;
    assign vfall = ~vs1_q & vs2_q;
    // A vsync edge takes effect on the hsync edge coinciding with it or first following it
    assign frame_evt = hedge & (vedge | vpend_q);

    assign hc_cur    = hedge ? '0 : ((hc_q == HC_MAX) ? HC_MAX : hc_q + 1'b1);
    assign timeout   = (hc_cur == HC_MAX);
    assign vc_cur    = hedge ? (frame_evt ? '0 : vc_q + 1'b1) : vc_q;
    assign line_len  = hc_q + 1'b1;
    assign frame_len = vc_q + 1'b1;
    assign line_ok   = (line_len == ref_ht_q) && (hsw_tmp_q == ref_hsw_q);
    assign frame_ok  = (frame_len == ref_vt_q) && (vsw_tmp_q == ref_vsw_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs1_q     <= 1'b0;
            hs2_q     <= 1'b0;
            vs1_q     <= 1'b0;
            vs2_q     <= 1'b0;
            rgb1_q    <= '0;
            hc_q      <= '0;
            vc_q      <= '0;
            vpend_q   <= 1'b0;
            hsw_tmp_q <= '0;
            vsw_cnt_q <= '0;
            vsw_tmp_q <= '0;
        end else begin
            hs1_q  <= hs_in;
            hs2_q  <= hs1_q;
            vs1_q  <= vs_in;
            vs2_q  <= vs1_q;
            rgb1_q <= {r_in, g_in, b_in};
            hc_q   <= hc_cur;
            vc_q   <= vc_cur;
            if (hedge) begin
                vpend_q <= 1'b0;
            end else if (vedge) begin
                vpend_q <= 1'b1;
            end
            if (hfall) begin
                hsw_tmp_q <= hc_cur;
            end
            // vsync width is counted in hsync edges seen while vsync is asserted
            if (vedge) begin
                vsw_cnt_q <= hedge ? CW'(1) : '0;
            end else if (hedge && vs1_q) begin
                vsw_cnt_q <= vsw_cnt_q + 1'b1;
            end
            if (vfall) begin
                vsw_tmp_q <= vsw_cnt_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        ref_ht_d  = ref_ht_q;
        ref_hsw_d = ref_hsw_q;
        ref_vt_d  = ref_vt_q;
        ref_vsw_d = ref_vsw_q;
        err_d     = 1'b0;
        load_out  = 1'b0;
        unique case (state_q)
            StSearch: begin
                if (frame_evt) begin
                    state_d = StMeasure;
                    first_d = 1'b1;
                end
            end
            StMeasure: begin
                if (timeout) begin
                    state_d = StSearch;
                end else if (hedge) begin
                    if (first_q) begin
                        ref_ht_d  = line_len;
                        ref_hsw_d = hsw_tmp_q;
                        first_d   = 1'b0;
                    end else if (!line_ok) begin
                        state_d = StSearch;
                    end else if (frame_evt) begin
                        ref_vt_d  = frame_len;
                        ref_vsw_d = vsw_tmp_q;
                        state_d   = StVerify;
                    end
                end
            end
            StVerify: begin
                if (timeout || (hedge && !line_ok)) begin
                    state_d = StSearch;
                end else if (frame_evt) begin
                    if (frame_ok) begin
                        state_d  = StLocked;
                        load_out = 1'b1;
                    end else begin
                        state_d = StSearch;
                    end
                end
            end
            StLocked: begin
                // A line past v_total without a frame edge means vsync went missing
                if (timeout || (hedge && !line_ok) || (frame_evt && !frame_ok) ||
                    (hedge && !frame_evt && (frame_len >= ref_vt_q))) begin
                    state_d = StSearch;
                    err_d   = 1'b1;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StSearch;
            first_q   <= 1'b0;
            ref_ht_q  <= '0;
            ref_hsw_q <= '0;
            ref_vt_q  <= '0;
            ref_vsw_q <= '0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            ref_ht_q  <= ref_ht_d;
            ref_hsw_q <= ref_hsw_d;
            ref_vt_q  <= ref_vt_d;
            ref_vsw_q <= ref_vsw_d;
        end
    end

    assign h_start = ref_hsw_q + H_BACK_W;
    assign v_start = ref_vsw_q + V_BACK_W;
    assign h_in    = (hc_cur >= h_start) && (hc_cur < h_start + H_DISP_W);
    assign v_in    = (vc_cur >= v_start) && (vc_cur < v_start + V_DISP_W);
    assign x_d     = hc_cur - h_start;
    assign y_d     = vc_cur - v_start;
    // Gate on the next state so de drops in the same cycle locked falls
    assign de_d    = (state_d == StLocked) && h_in && v_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            r_out       <= 1'b0;
            g_out       <= 1'b0;
            b_out       <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
            h_total     <= '0;
            h_sw        <= '0;
            v_total     <= '0;
            v_sw        <= '0;
        end else begin
            x           <= de_d ? x_d : '0;
            y           <= de_d ? y_d : '0;
            de          <= de_d;
            {r_out, g_out, b_out} <= rgb1_q;
            frame_start <= de_d && (x_d == '0) && (y_d == '0);
            locked      <= (state_d == StLocked);
            err         <= err_d;
            if (load_out) begin
                h_total <= ref_ht_q;
                h_sw    <= ref_hsw_q;
                v_total <= ref_vt_q;
                v_sw    <= ref_vsw_q;
            end
        end
    end

endmodule

// File: doc/vga_rx_timing.md
Name: vga_rx_timing

Overview:
- Receive end of the VGA link: consumes hsync/vsync/RGB produced by the timing generator and test-pattern path, all on the same pixel clock.
- Measures line and frame geometry, locks onto a stable raster, then regenerates pixel coordinates, a data-enable, and registered RGB for capture and checking.
- Sits in the simulation bench or on-chip loopback between the pattern source and pixel checkers or frame capture.

Parameters:
- H_BACK, 48, back-porch pixels after hsync deassertion before the first active pixel
- H_DISP, 640, active pixels per line
- V_BACK, 33, back-porch lines after vsync deassertion before the first active line
- V_DISP, 480, active lines per frame
- SYNC_POL, 0, 0 = sync pulses active-low, 1 = active-high (applies to hsync and vsync)
- CW, 12, width of all internal counters and measurement outputs

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hsync  in  1  horizontal sync from the link
- vsync  in  1  vertical sync from the link
- r_in, g_in, b_in  in  1 each  pixel colour bits
- x  out  CW  active pixel column, valid when de=1
- y  out  CW  active line, valid when de=1
- de  out  1  active-pixel strobe, asserted only while locked
- r_out, g_out, b_out  out  1 each  colour aligned with x, y, de
- frame_start  out  1  one-cycle pulse with the first active pixel of each locked frame
- locked  out  1  geometry stable
- err  out  1  one-cycle pulse on any loss of lock
- h_total, h_sw, v_total, v_sw  out  CW each  measured line period, hsync width, lines per frame, and vsync width in lines

Behaviour:
- Reset: all outputs 0, FSM in SEARCH, all counters 0. Reset takes effect immediately at any point, including mid-frame.
- Input stage:
  - hsync, vsync, and RGB are registered once (stage s1).
  - Syncs are polarity-normalised so asserted = 1.
  - An assertion edge is s1 = 1 with the previous s1 = 0.
- Horizontal counter hc:
  - hc = 0 on the cycle an hsync assertion edge is seen, otherwise hc + 1.
  - hc saturates at 2^CW-1, which is a timeout.
  - The hsync width latches into a temporary register on deassertion.
- Vertical counter vc:
  - vc = 0 on the hsync edge coinciding with, or first following, a vsync assertion edge.
  - Otherwise vc increments on each hsync edge.
  - vsync width is counted in hsync edges.
- FSM:
  - SEARCH: wait for a vsync assertion edge, then go to MEASURE.
  - MEASURE: over one frame, record h_total (hc+1 at each hsync edge), h_sw, v_total, and v_sw.
    - Every line of the frame must give an identical h_total and h_sw; any mismatch restarts SEARCH. No err in this state.
    - At the next vsync edge, go to VERIFY.
  - VERIFY: the second frame must reproduce all four measurements exactly.
    - Match at the next vsync edge: go to LOCKED and set locked = 1.
    - Mismatch: go to SEARCH.
  - LOCKED: every line and frame is checked against the stored values.
    - Any mismatch, hc timeout, or vsync edge at a vc different from v_total: pulse err for one cycle, clear locked, go to SEARCH.
  - Measurement outputs update only on entry to LOCKED and hold their values while unlocked.
- Active window (LOCKED only):
  - Horizontal: hc in [h_sw+H_BACK, h_sw+H_BACK+H_DISP).
  - Vertical: vc in [v_sw+V_BACK, v_sw+V_BACK+V_DISP).
  - x = hc - (h_sw+H_BACK) and y = vc - (v_sw+V_BACK), both truncated to CW.
- Output timing:
  - x, y, de, and RGB are registered, giving latency 2 clk from the pins to the outputs.
  - frame_start = de with x = 0 and y = 0.
  - de = 0 on the cycle locked falls.
- Simultaneous hsync and vsync edges: the line edge is processed first, then vc clears.
- Total latency to lock: first vsync edge + 2 full frames.

Test Plan:
- Drive 640x480 timing (h_total 800, hsync width 96, v_total 525, vsync 2 lines, active-low) -> locked rises at the third vsync assertion edge; h_total = 800, h_sw = 96, v_total = 525, v_sw = 2; err stays 0.
- After lock, sample the first active pixel -> de rises 2 clk after the pins show hc = 144 on line vc = 35; x = 0, y = 0, frame_start = 1; the last de is at x = 639, y = 479; exactly 307200 de cycles per frame.
- Quadrant pattern (red top-left, blue top-right, green bottom-left, black bottom-right, white 8-pixel cross) -> (x=10, y=10) gives r=1, g=0, b=0; (630, 10) gives b only; (10, 470) gives g only; (630, 470) gives 000; (320, 240) gives 111.
- While locked, stretch one line to 801 cycles -> err pulses once, locked = 0 and de = 0 from the next cycle; relock after 2 clean frames with the measurements unchanged.
- Hold hsync deasserted for 4096 cycles while locked -> timeout, err pulse, return to SEARCH.
- Assert rst_n low mid-frame while locked -> all outputs 0 asynchronously; after release, lock requires a fresh vsync edge + 2 frames.
